// File: rtl/status_value_pkg.sv
// Shared types for the status value reader: FSM state encoding and default data width.
package status_value_pkg;

  localparam int SVR_WIDTH = 8;

  typedef enum logic [1:0] {
    SVR_EMPTY = 2'd0,
    SVR_ONE   = 2'd1,
    SVR_TWO   = 2'd2,
    SVR_FLUSH = 2'd3
  } svr_state_e;

endpackage

// File: rtl/status_value_skid.sv
// Output register plus one skid register; the output register always holds the older entry.
module status_value_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             load_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] out_value_o,
  output logic             out_valid_o
);

  logic [WIDTH-1:0] out_value_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] skid_value_q;
  logic             skid_valid_q;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      out_value_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_value_q <= '0;
      skid_valid_q <= 1'b0;
    end else if (clear_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || pop_i) begin
      // Output slot frees up: the skid entry is older than anything arriving now.
      if (skid_valid_q) begin
        out_value_q  <= skid_value_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= load_i;
        if (load_i) skid_value_q <= data_i;
      end else begin
        out_valid_q <= load_i;
        if (load_i) out_value_q <= data_i;
      end
    end else if (load_i) begin
      skid_value_q <= data_i;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_value_o = out_value_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/status_value_reader.sv
// Drains the status value vector into a valid/ready sink via a 2-entry skid buffer, with flush.
// Optional delivered-entry counter enabled by defining STATUS_READER_COUNT_EN.
module status_value_reader
  import status_value_pkg::*;
#(
  parameter int WIDTH   = SVR_WIDTH,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rsn_i,
  input  logic [WIDTH-1:0]   vec_value_i,
  input  logic               vec_valid_i,
  input  logic               vec_full_i,
  output logic               vec_pull_o,
  output logic [WIDTH-1:0]   out_value_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               stall_o,
  output logic [COUNT_W-1:0] count_o
);

  svr_state_e state_q;
  logic       flush_done_q;
  logic       flushing;
  logic       space;
  logic       pop;
  logic       pull;

  assign flushing = (state_q == SVR_FLUSH);
  assign space    = (state_q == SVR_EMPTY) || (state_q == SVR_ONE);
  // A flush request wins over a simultaneous handshake: nothing is delivered that cycle.
  assign pop      = out_valid_o & out_ready_i & ~flush_i;
  assign pull     = rsn_i & vec_valid_i & (space | flushing) & ~flush_i;

  assign vec_pull_o   = pull;
  assign stall_o      = vec_full_i & (state_q == SVR_TWO);
  assign flush_done_o = flush_done_q;

  status_value_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .load_i      (pull & ~flushing),
    .pop_i       (pop),
    .clear_i     (flush_i),
    .data_i      (vec_value_i),
    .out_value_o (out_value_o),
    .out_valid_o (out_valid_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q      <= SVR_EMPTY;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        SVR_EMPTY: begin
          if (flush_i)   state_q <= SVR_FLUSH;
          else if (pull) state_q <= SVR_ONE;
        end
        SVR_ONE: begin
          if (flush_i)           state_q <= SVR_FLUSH;
          else if (pull && !pop) state_q <= SVR_TWO;
          else if (!pull && pop) state_q <= SVR_EMPTY;
        end
        SVR_TWO: begin
          if (flush_i)  state_q <= SVR_FLUSH;
          else if (pop) state_q <= SVR_ONE;
        end
        SVR_FLUSH: begin
          // Pulled values are simply dropped; the flush ends once the vector runs dry.
          if (!vec_valid_i) begin
            state_q      <= SVR_EMPTY;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= SVR_EMPTY;
      endcase
    end
  end

`ifdef STATUS_READER_COUNT_EN
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (pop) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
`else
  assign count_o = '0;
`endif

endmodule

// File: tb/tb_status_value_reader.sv
// Directed bench for status_value_reader with a queue-level reference model checked every cycle.
module tb_status_value_reader;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rsn_i = 1'b0;
  logic [W-1:0]  vec_value_i = '0;
  logic          vec_valid_i = 1'b0;
  logic          vec_full_i = 1'b0;
  logic          vec_pull_o;
  logic [W-1:0]  out_value_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic          stall_o;
  logic [CW-1:0] count_o;

  status_value_reader #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk_i        (clk),
    .rsn_i        (rsn_i),
    .vec_value_i  (vec_value_i),
    .vec_valid_i  (vec_valid_i),
    .vec_full_i   (vec_full_i),
    .vec_pull_o   (vec_pull_o),
    .out_value_o  (out_value_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .stall_o      (stall_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the vector as a queue, the reader's buffer as a queue of held entries.
  logic [W-1:0]  vq[$];
  logic [W-1:0]  mb[$];
  logic [W-1:0]  seen[$];
  bit            flushing = 1'b0;
  bit            m_done = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  bit            chk_en = 1'b0;
  bit            win = 1'b0;
  int            win_pulls = 0;
  int            win_dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_pull();
    return rsn_i && vec_valid_i && (flushing || mb.size() < 2) && !flush_i;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef STATUS_READER_COUNT_EN
    return m_cnt;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] lit_cnt(input int n);
`ifdef STATUS_READER_COUNT_EN
    return CW'(n);
`else
    return CW'(0 * n);
`endif
  endfunction

  task automatic drive_vec();
    vec_valid_i = (vq.size() != 0);
    vec_value_i = (vq.size() != 0) ? vq[0] : '0;
  endtask

  task automatic step();
    bit p;
    bit pop;
    bit had;
    logic [W-1:0] tmp;
    @(posedge clk);
    p   = exp_pull();
    had = vec_valid_i;
    pop = rsn_i && out_ready_i && !flushing && (mb.size() != 0) && !flush_i;
    if (!rsn_i) begin
      mb.delete();
      flushing = 1'b0;
      m_done   = 1'b0;
      m_cnt    = '0;
    end else begin
      m_done = 1'b0;
      if (flushing) begin
        if (p) tmp = vq.pop_front();
        if (!had) begin
          flushing = 1'b0;
          m_done   = 1'b1;
        end
      end else if (flush_i) begin
        mb.delete();
        flushing = 1'b1;
      end else begin
        if (pop) begin
          tmp = mb.pop_front();
          m_cnt = m_cnt + 1'b1;
        end
        if (p) begin
          tmp = vq.pop_front();
          mb.push_back(tmp);
        end
      end
    end
    #1;
    drive_vec();
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pull",  32'(vec_pull_o),   32'(exp_pull()));
      chk("valid", 32'(out_valid_o),  32'(!flushing && mb.size() != 0));
      if (!flushing && mb.size() != 0)
        chk("value", 32'(out_value_o), 32'(mb[0]));
      chk("done",  32'(flush_done_o), 32'(m_done));
      chk("stall", 32'(stall_o),      32'(vec_full_i && !flushing && mb.size() == 2));
      chk("count", 32'(count_o),      32'(exp_cnt()));
      if (rsn_i && out_valid_o && out_ready_i && !flush_i) seen.push_back(out_value_o);
      if (win) begin
        win_pulls += int'(vec_pull_o);
        win_dones += int'(flush_done_o);
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    // Reset held with a valid entry waiting.
    vq.push_back(8'hAA);
    drive_vec();
    step();
    chk_en = 1'b1;
    step();
    step();
    at_neg();
    chk("rst_pull",  32'(vec_pull_o),   32'h0);
    chk("rst_valid", 32'(out_valid_o),  32'h0);
    chk("rst_value", 32'(out_value_o),  32'h0);
    chk("rst_done",  32'(flush_done_o), 32'h0);
    chk("rst_count", 32'(count_o),      32'h0);
    step();

    // Streaming at full rate.
    rsn_i = 1'b1;
    out_ready_i = 1'b1;
    vq.delete();
    vq.push_back(8'h11); vq.push_back(8'h22); vq.push_back(8'h33);
    seen.delete();
    drive_vec();
    at_neg();
    chk("stream_first_pull", 32'(vec_pull_o), 32'h1);
    step();
    at_neg();
    chk("stream_lat1", 32'({out_valid_o, out_value_o}), 32'h111);
    repeat (4) step();
    at_neg();
    chk("stream_n",  32'(seen.size()), 32'd3);
    chk("stream_0",  32'(seen[0]), 32'h11);
    chk("stream_1",  32'(seen[1]), 32'h22);
    chk("stream_2",  32'(seen[2]), 32'h33);
    chk("stream_cnt", 32'(count_o), 32'(lit_cnt(3)));

    // Backpressure into the skid register, with stall.
    step();
    out_ready_i = 1'b0;
    seen.delete();
    vq.push_back(8'h11); vq.push_back(8'h22); vq.push_back(8'h33);
    drive_vec();
    step();
    step();
    vec_full_i = 1'b1;
    at_neg();
    chk("bp_nopull", 32'(vec_pull_o),  32'h0);
    chk("bp_valid",  32'(out_valid_o), 32'h1);
    chk("bp_value",  32'(out_value_o), 32'h11);
    chk("bp_stall",  32'(stall_o),     32'h1);
    step();
    out_ready_i = 1'b1;
    at_neg();
    chk("bp_stable", 32'(out_value_o), 32'h11);
    chk("bp_stall2", 32'(stall_o),     32'h1);
    step();
    at_neg();
    chk("bp_unstall", 32'(stall_o),     32'h0);
    chk("bp_next",    32'(out_value_o), 32'h22);
    step();
    vec_full_i = 1'b0;
    repeat (3) step();
    at_neg();
    chk("bp_n",   32'(seen.size()), 32'd3);
    chk("bp_0",   32'(seen[0]), 32'h11);
    chk("bp_1",   32'(seen[1]), 32'h22);
    chk("bp_2",   32'(seen[2]), 32'h33);
    chk("bp_cnt", 32'(count_o), 32'(lit_cnt(6)));

    // Flush from TWO with four entries left in the vector.
    step();
    out_ready_i = 1'b0;
    vq.push_back(8'h11); vq.push_back(8'h22);
    vq.push_back(8'h41); vq.push_back(8'h42); vq.push_back(8'h43); vq.push_back(8'h44);
    drive_vec();
    step();
    step();
    step();
    flush_i = 1'b1;
    win = 1'b1; win_pulls = 0; win_dones = 0;
    at_neg();
    chk("fl_nopull", 32'(vec_pull_o), 32'h0);
    step();
    flush_i = 1'b0;
    at_neg();
    chk("fl_valid0", 32'(out_valid_o), 32'h0);
    repeat (6) step();
    at_neg();
    win = 1'b0;
    chk("fl_pulls", 32'(win_pulls), 32'd4);
    chk("fl_dones", 32'(win_dones), 32'd1);
    chk("fl_cnt",   32'(count_o),   32'(lit_cnt(6)));
    chk("fl_empty", 32'(out_valid_o), 32'h0);

    // Flush colliding with a pop and a pending entry, then reset mid-flush.
    step();
    out_ready_i = 1'b1;
    vq.push_back(8'h61); vq.push_back(8'h62);
    drive_vec();
    step();
    flush_i = 1'b1;
    win = 1'b1; win_pulls = 0; win_dones = 0;
    at_neg();
    chk("cr_nopull", 32'(vec_pull_o), 32'h0);
    step();
    flush_i = 1'b0;
    at_neg();
    chk("cr_cnt",    32'(count_o),     32'(lit_cnt(6)));
    chk("cr_valid0", 32'(out_valid_o), 32'h0);
    chk("cr_fpull",  32'(vec_pull_o),  32'h1);
    rsn_i = 1'b0;
    step();
    rsn_i = 1'b1;
    at_neg();
    chk("cr_rst_valid", 32'(out_valid_o),  32'h0);
    chk("cr_rst_done",  32'(flush_done_o), 32'h0);
    chk("cr_rst_cnt",   32'(count_o),      32'h0);
    step();
    at_neg();
    chk("cr_after", 32'({out_valid_o, out_value_o}), 32'h162);
    step();
    step();
    at_neg();
    win = 1'b0;
    chk("cr_nodone", 32'(win_dones), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
